// File: rtl/tone_generator_if.sv
// Sample stream and control bundle for the tone generator.
// The master side is the generator; the slave side is the sample consumer / controller.
interface tone_generator_if #(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 32
);
    logic              enable;
    logic [ACC_W-1:0]  freq_word;
    logic [1:0]        mode;
    logic [DATA_W-2:0] amplitude;
    logic              sample_ready;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_out;

    modport master (
        input  enable,
        input  freq_word,
        input  mode,
        input  amplitude,
        input  sample_ready,
        output sample_valid,
        output sample_out
    );

    modport slave (
        output enable,
        output freq_word,
        output mode,
        output amplitude,
        output sample_ready,
        input  sample_valid,
        input  sample_out
    );
endinterface

// File: rtl/tone_generator.sv
// Phase-accumulator tone generator: square / sawtooth / triangle shapes scaled by an
// unsigned amplitude, delivered one sample per valid/ready transfer.
// Frequency, shape and amplitude changes are latched only at a period boundary
// (accumulator carry-out) or after a disabled transfer, so a running tone never
// switches mid-period. Enable acts immediately on the waveform.
module tone_generator #(
    parameter int                DATA_W      = 24,
    parameter int                ACC_W       = 32,
    parameter logic [DATA_W-1:0] DEFAULT_AMP = 24'h000100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    tone_generator_if.master bus
);

    localparam logic [1:0] SHAPE = 2'd0;
    localparam logic [1:0] MULT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Full-scale unit waveform values +M and -M
    localparam logic signed [DATA_W-1:0] W_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] W_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    logic [1:0]               state_q, state_d;
    logic [ACC_W-1:0]         phase_q, phase_d;
    logic                     load_pending_q, load_pending_d;
    logic [ACC_W-1:0]         freq_s_q, freq_s_d;
    logic [1:0]               mode_s_q, mode_s_d;
    logic [DATA_W-2:0]        amp_s_q, amp_s_d;
    logic signed [DATA_W-1:0] w_q, w_d;
    logic [DATA_W-1:0]        sample_q, sample_d;

    logic [1:0]               mode_eff;
    logic [DATA_W-1:0]        p_vec;
    logic [DATA_W-1:0]        q_vec;
    logic [DATA_W-1:0]        u_vec;
    logic signed [DATA_W-1:0] shape_w;
    logic [ACC_W:0]           phase_sum;
    logic [2*DATA_W-1:0]      w_ext;
    logic [2*DATA_W-1:0]      amp_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]        scaled;
    logic                     unused_prod;

    // Unit waveform from the current phase; a pending load means the new mode applies now
    always_comb begin
        mode_eff = load_pending_q ? bus.mode : mode_s_q;
        p_vec    = phase_q[ACC_W-1 -: DATA_W];
        q_vec    = phase_q[ACC_W-2 -: DATA_W];
        u_vec    = phase_q[ACC_W-1] ? ~q_vec : q_vec;
        shape_w  = '0;
        if (bus.enable) begin
            case (mode_eff)
                2'b00:   shape_w = phase_q[ACC_W-1] ? W_NEG : W_POS;
                2'b01:   shape_w = {~p_vec[DATA_W-1], p_vec[DATA_W-2:0]};
                2'b10:   shape_w = {~u_vec[DATA_W-1], u_vec[DATA_W-2:0]};
                default: shape_w = '0;
            endcase
        end
    end

    // Amplitude scaling: full-width signed product, floor shift by DATA_W-1, truncated
    always_comb begin
        w_ext       = {{DATA_W{w_q[DATA_W-1]}}, w_q};
        amp_ext     = {{(DATA_W+1){1'b0}}, amp_s_q};
        prod        = $signed(w_ext) * $signed(amp_ext);
        scaled      = prod[2*DATA_W-2 -: DATA_W];
        unused_prod = ^{prod[2*DATA_W-1], prod[DATA_W-2:0]};
    end

    // Next-state logic for the SHAPE -> MULT -> HOLD sample pipeline and phase accumulator
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        load_pending_d = load_pending_q;
        freq_s_d       = freq_s_q;
        mode_s_d       = mode_s_q;
        amp_s_d        = amp_s_q;
        w_d            = w_q;
        sample_d       = sample_q;
        phase_sum      = {1'b0, phase_q} + {1'b0, freq_s_q};
        case (state_q)
            SHAPE: begin
                state_d = MULT;
                w_d     = shape_w;
                if (load_pending_q) begin
                    freq_s_d       = bus.freq_word;
                    mode_s_d       = bus.mode;
                    amp_s_d        = bus.amplitude;
                    load_pending_d = 1'b0;
                end
            end
            MULT: begin
                state_d  = HOLD;
                sample_d = scaled;
            end
            HOLD: begin
                if (bus.sample_ready) begin
                    state_d = SHAPE;
                    if (bus.enable) begin
                        phase_d = phase_sum[ACC_W-1:0];
                        if (phase_sum[ACC_W]) begin
                            load_pending_d = 1'b1;
                        end
                    end else begin
                        phase_d        = '0;
                        load_pending_d = 1'b1;
                    end
                end
            end
            default: state_d = SHAPE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q        <= SHAPE;
            phase_q        <= '0;
            load_pending_q <= 1'b1;
            freq_s_q       <= '0;
            mode_s_q       <= 2'b00;
            amp_s_q        <= DEFAULT_AMP[DATA_W-2:0];
            w_q            <= '0;
            sample_q       <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            load_pending_q <= load_pending_d;
            freq_s_q       <= freq_s_d;
            mode_s_q       <= mode_s_d;
            amp_s_q        <= amp_s_d;
            w_q            <= w_d;
            sample_q       <= sample_d;
        end
    end

    assign bus.sample_valid = (state_q == HOLD);
    assign bus.sample_out   = sample_q;

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: stimulus pushes expected samples, a negedge
// monitor pops and compares on each valid/ready transfer.
module tb_tone_generator;

    logic clk;
    logic rst_n;

    tone_generator_if #(.DATA_W(24), .ACC_W(32)) bus_if ();

    tone_generator #(.DATA_W(24), .ACC_W(32), .DEFAULT_AMP(24'h000100)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];

    // Reference model state
    longint      m_phase;
    bit          m_pend;
    longint      m_freq;
    int          m_mode;
    longint      m_amp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pend  = 1'b1;
        m_freq  = 0;
        m_mode  = 0;
        m_amp   = 64'h100;
    endtask

    // One sample: latch settings if pending, shape, scale with floor, then advance phase
    function automatic logic [23:0] model_step(input bit en, input logic [31:0] fw,
                                               input logic [1:0] md, input logic [22:0] amp);
        longint mfull;
        longint w;
        longint p;
        longint q;
        longint u;
        longint prodv;
        longint res;
        longint s;
        logic [63:0] resv;
        mfull = 64'd8388607;
        if (m_pend) begin
            m_freq = fw;
            m_mode = md;
            m_amp  = amp;
            m_pend = 1'b0;
        end
        p = m_phase / 256;
        q = (m_phase / 128) % 64'd16777216;
        w = 0;
        if (en) begin
            case (m_mode)
                0: w = (m_phase >= 64'h8000_0000) ? -mfull : mfull;
                1: w = p - 64'd8388608;
                2: begin
                    u = (m_phase >= 64'h8000_0000) ? (64'd16777215 - q) : q;
                    w = u - 64'd8388608;
                end
                default: w = 0;
            endcase
        end
        prodv = w * m_amp;
        res   = prodv >>> 23;
        resv  = res;
        if (en) begin
            s = m_phase + m_freq;
            if (s >= 64'h1_0000_0000) begin
                s      = s - 64'h1_0000_0000;
                m_pend = 1'b1;
            end
            m_phase = s;
        end else begin
            m_phase = 0;
            m_pend  = 1'b1;
        end
        return resv[23:0];
    endfunction

    // Apply settings just after a transfer edge, queue the expected sample and
    // check valid stays low 2 cycles before rising
    task automatic start_sample(input bit en, input logic [31:0] fw, input logic [1:0] md,
                                input logic [22:0] amp, input int hold,
                                input bit use_lit, input logic [23:0] lit);
        logic [23:0] e;
        bus_if.enable       = en;
        bus_if.freq_word    = fw;
        bus_if.mode         = md;
        bus_if.amplitude    = amp;
        bus_if.sample_ready = (hold == 0);
        e = model_step(en, fw, md, amp);
        exp_q.push_back(use_lit ? lit : e);
        @(negedge clk);
        check("valid_low1", {31'd0, bus_if.sample_valid}, 32'd0);
        @(negedge clk);
        check("valid_low2", {31'd0, bus_if.sample_valid}, 32'd0);
        @(negedge clk);
        check("valid_rise", {31'd0, bus_if.sample_valid}, 32'd1);
    endtask

    // Stall for 'hold' cycles checking the sample stays put, then transfer
    task automatic finish_sample(input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, bus_if.sample_valid}, 32'd1);
            check("hold_data", {8'd0, bus_if.sample_out}, {8'd0, exp_q[0]});
            @(posedge clk);
            #1;
        end
        if (hold != 0) begin
            bus_if.sample_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_sample(input bit en, input logic [31:0] fw, input logic [1:0] md,
                             input logic [22:0] amp, input int hold,
                             input bit use_lit, input logic [23:0] lit);
        start_sample(en, fw, md, amp, hold, use_lit, lit);
        finish_sample(hold);
    endtask

    // Monitor: every accepted sample is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus_if.sample_valid && bus_if.sample_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sample: got %h with no expected entry", bus_if.sample_out);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                total++;
                if (bus_if.sample_out !== e) begin
                    bad++;
                    $display("FAIL sample: got %h want %h", bus_if.sample_out, e);
                end else begin
                    $display("sample ok %h", bus_if.sample_out);
                end
            end
        end
    end

    logic [23:0] sq_seq [4];
    logic [23:0] saw_seq [4];

    initial begin
        sq_seq[0]  = 24'h0000FF; sq_seq[1]  = 24'h0000FF;
        sq_seq[2]  = 24'hFFFF00; sq_seq[3]  = 24'hFFFF00;
        saw_seq[0] = 24'h800001; saw_seq[1] = 24'hC00000;
        saw_seq[2] = 24'h000000; saw_seq[3] = 24'h3FFFFF;

        rst_n               = 1'b0;
        bus_if.enable       = 1'b1;
        bus_if.freq_word    = 32'h4000_0000;
        bus_if.mode         = 2'b00;
        bus_if.amplitude    = 23'h000100;
        bus_if.sample_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, bus_if.sample_valid}, 32'd0);
        check("reset_data", {8'd0, bus_if.sample_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Square at a quarter of the sample rate, back-to-back ready
        for (int i = 0; i < 8; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b00, 23'h000100, 0, 1'b1, sq_seq[i % 4]);

        // Sawtooth at full amplitude, floor rounding on negative products
        for (int i = 0; i < 4; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b01, 23'h7FFFFF, 0, 1'b1, saw_seq[i]);

        // Long stall in HOLD
        do_sample(1'b1, 32'h4000_0000, 2'b01, 23'h7FFFFF, 10, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b01, 23'h7FFFFF, 0, 1'b0, 24'h0);

        // Square then switch to triangle with a new frequency mid-period
        for (int i = 0; i < 2; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b00, 23'h7FFFFF, 0, 1'b0, 24'h0);
        for (int i = 0; i < 10; i++)
            do_sample(1'b1, 32'h1000_0000, 2'b10, 23'h7FFFFF, i % 2, 1'b0, 24'h0);

        // One disabled transfer restarts the square sequence from phase 0
        do_sample(1'b0, 32'h4000_0000, 2'b00, 23'h000100, 0, 1'b1, 24'h000000);
        for (int i = 0; i < 4; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b00, 23'h000100, 0, 1'b1, sq_seq[i]);

        // DC output with a zero frequency word
        for (int i = 0; i < 3; i++)
            do_sample(1'b1, 32'h0, 2'b00, 23'h000100, 0, 1'b1, 24'h0000FF);

        // Randomized settings, enables and stalls
        for (int i = 0; i < 40; i++) begin
            logic [31:0] fw;
            case ($urandom_range(0, 3))
                0:       fw = 32'h0;
                1:       fw = 32'h1 << $urandom_range(26, 31);
                default: fw = $urandom;
            endcase
            do_sample($urandom_range(0, 7) != 0, fw, 2'($urandom_range(0, 3)),
                      23'($urandom), $urandom_range(0, 3), 1'b0, 24'h0);
        end

        // Asynchronous reset while a sample is waiting in HOLD
        start_sample(1'b1, 32'h4000_0000, 2'b01, 23'h7FFFFF, 1, 1'b0, 24'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus_if.sample_valid}, 32'd0);
        check("async_rst_data", {8'd0, bus_if.sample_out}, 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++)
            do_sample(1'b1, 32'h4000_0000, 2'b00, 23'h000100, 0, 1'b1, sq_seq[i]);

        bus_if.sample_ready = 1'b0;
        repeat (4) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, the sample width in two's complement.
REQ-002 The block SHALL have parameter ACC_W, default 32, the phase accumulator width (ACC_W >= DATA_W+1).
REQ-003 The block SHALL have parameter DEFAULT_AMP, default 24'h000100, the amplitude loaded at reset.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: 1 runs the oscillator, 0 outputs silence.
REQ-007 The block SHALL have port freq_word, input, ACC_W bits: phase increment per sample (f = freq_word*Fs/2^ACC_W).
REQ-008 The block SHALL have port mode, input, 2 bits: 00 square, 01 sawtooth, 10 triangle, 11 silence.
REQ-009 The block SHALL have port amplitude, input, DATA_W-1 bits: unsigned magnitude scale.
REQ-010 The block SHALL have port sample_ready, input, 1 bit: the consumer (codec FIFO) accepts a sample.
REQ-011 The block SHALL have port sample_valid, output, 1 bit: sample_out holds a sample.
REQ-012 The block SHALL have port sample_out, output, DATA_W bits: signed sample.

Function
REQ-013 The block SHALL implement a 3-state FSM: SHAPE, MULT, HOLD; SHAPE->MULT->HOLD unconditionally; HOLD->SHAPE on sample_valid&&sample_ready; otherwise it SHALL stay in HOLD.
REQ-014 sample_valid SHALL be high exactly while in HOLD; sample_out SHALL stay stable while sample_valid=1 and sample_ready=0.
REQ-015 Transfer SHALL occur on a rising edge with sample_valid&&sample_ready; on that edge, phase <= phase + freq_word (mod 2^ACC_W) if enable=1, else phase <= 0.
REQ-016 After a transfer, sample_valid SHALL be low for exactly 2 cycles; back-to-back ready therefore yields one sample per 3 cycles.
REQ-017 Shadow registers freq_s, mode_s and amp_s SHALL load from freq_word, mode and amplitude in SHAPE only when load_pending=1; load_pending SHALL be cleared there.
REQ-018 load_pending SHALL be set by reset, by a transfer with enable=0, or by a transfer whose phase addition carries out of bit ACC_W-1, so that changes take effect only at a period boundary.
REQ-019 In SHAPE, the block SHALL register unit waveform w (DATA_W signed), with M = 2^(DATA_W-1)-1 and P = phase[ACC_W-1 -: DATA_W].
REQ-020 For square, w SHALL be +M when phase MSB=0 and -M otherwise.
REQ-021 For sawtooth, w SHALL be P with its MSB inverted.
REQ-022 For triangle, with q = phase[ACC_W-2 -: DATA_W] and u = phase MSB ? ~q : q, w SHALL be u with its MSB inverted.
REQ-023 For silence, or when enable=0, w SHALL be 0.
REQ-024 In MULT, the block SHALL register sample_out = (w * signed{1'b0,amp_s}) >>> (DATA_W-1), using an arithmetic floor shift on the full 2*DATA_W product, truncated to DATA_W bits.
REQ-025 freq_word=0 SHALL hold the phase constant, giving a DC sample of the current shape; it SHALL NOT be an error.
REQ-026 An enable change SHALL affect w at the next SHAPE state, without waiting for the period boundary.

Reset
REQ-027 On reset low, regardless of clock, the block SHALL set the FSM to SHAPE, sample_valid=0, sample_out=0, phase=0, load_pending=1, freq_s=0, mode_s=00 and amp_s=DEFAULT_AMP.
REQ-028 Reset asserted mid-HOLD SHALL drop sample_valid immediately and discard the pending sample.
REQ-029 After reset deasserts, sample_valid SHALL rise after the second rising edge of CLOCK_50.

Verification
REQ-030 Square, amplitude=0x000100, freq_word=0x40000000, enable=1, ready always 1 -> sample_out sequence 0x0000FF, 0x0000FF, 0xFFFF00, 0xFFFF00, repeating; valid high 1 cycle in 3.
REQ-031 Sawtooth, freq_word=0x40000000, amplitude=0x7FFFFF -> samples 0x800001, 0xC00000, 0x000000, 0x3FFFFF (floor rounding checked).
REQ-032 Hold sample_ready=0 for 10 cycles in HOLD -> sample_out and sample_valid remain constant; phase does not advance.
REQ-033 Change mode square->triangle and freq_word mid-period -> old shape and frequency continue until the sample following the accumulator carry-out, then the new settings apply.
REQ-034 Drop enable for one transfer -> the next sample is 0 and phase restarts at 0; re-enable -> the sequence restarts as in REQ-030.
REQ-035 Assert reset asynchronously between clock edges while sample_valid=1 -> sample_valid=0 and sample_out=0 before the next edge; first valid occurs 2 edges after release.
